// File: rtl/keccak_pkg.sv
// Shared constants and state encoding for the Keccak round sequencer.
package keccak_pkg;

  localparam int KECCAK_NUM_ROUNDS = 24;
  localparam int KECCAK_RND_W      = 5;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ROUND,
    DONE
  } keccak_ctrl_state_t;

endpackage

// File: rtl/keccak_round_ctrl_if.sv
// Request/result handshake between a permutation client and the
// round sequencer.
interface keccak_round_ctrl_if #(
  parameter int RND_W = 5,
  parameter int CNT_W = 16
);

  logic             start;
  logic             abort;
  logic             result_ack;
  logic             ready;
  logic             load_state;
  logic             round_en;
  logic [RND_W-1:0] round_number;
  logic             last_round;
  logic             done;
  logic [CNT_W-1:0] perm_count;

  modport master (
    output start,
    output abort,
    output result_ack,
    input  ready,
    input  load_state,
    input  round_en,
    input  round_number,
    input  last_round,
    input  done,
    input  perm_count
  );

  modport slave (
    input  start,
    input  abort,
    input  result_ack,
    output ready,
    output load_state,
    output round_en,
    output round_number,
    output last_round,
    output done,
    output perm_count
  );

endinterface

// File: rtl/keccak_round_ctrl.sv
// Sequences one Keccak-f permutation: load pulse, NUM_ROUNDS round
// steps, then a held done until the consumer acknowledges.
module keccak_round_ctrl
  import keccak_pkg::*;
#(
  parameter int NUM_ROUNDS = KECCAK_NUM_ROUNDS,
  parameter int RND_W      = KECCAK_RND_W,
  parameter int CNT_W      = 16
) (
  input logic            clk,
  input logic            rst,
  keccak_round_ctrl_if.slave bus
);

  localparam logic [RND_W-1:0] RC_LAST = RND_W'(NUM_ROUNDS - 1);

  keccak_ctrl_state_t state, state_n;
  logic [RND_W-1:0]   rc, rc_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               at_last;

  assign at_last = (rc == RC_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rc    <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      rc    <= rc_n;
      cnt   <= cnt_n;
    end
  end

  // abort dominates every transition and never counts a permutation
  always_comb begin
    state_n = state;
    rc_n    = rc;
    cnt_n   = cnt;
    unique case (state)
      IDLE: begin
        if (bus.start && !bus.abort)
          state_n = LOAD;
      end
      LOAD: begin
        rc_n    = '0;
        state_n = bus.abort ? IDLE : ROUND;
      end
      ROUND: begin
        if (bus.abort) begin
          rc_n    = '0;
          state_n = IDLE;
        end else if (at_last) begin
          rc_n    = '0;
          cnt_n   = cnt + CNT_W'(1);
          state_n = DONE;
        end else begin
          rc_n    = rc + RND_W'(1);
        end
      end
      DONE: begin
        if (bus.abort || bus.result_ack)
          state_n = IDLE;
      end
      default: begin
        rc_n    = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign bus.ready        = (state == IDLE);
  assign bus.load_state   = (state == LOAD);
  assign bus.round_en     = (state == ROUND);
  assign bus.round_number = bus.round_en ? rc : '0;
  assign bus.last_round   = bus.round_en && at_last;
  assign bus.done         = (state == DONE);
  assign bus.perm_count   = cnt;

endmodule

// File: tb/tb_keccak_round_ctrl.sv
// Scoreboard bench for keccak_round_ctrl: default build plus a
// single-round, 2-bit-counter build.
module tb_keccak_round_ctrl;

  localparam int NR = 24;

  typedef enum int {EV_LOAD, EV_ROUND, EV_DONE} ev_kind_t;
  typedef struct {
    ev_kind_t kind;
    int       cyc;
    int       val;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  bit   done_q = 1'b0;
  bit   done1_q = 1'b0;

  ev_t exq[$];
  int  q1[$];

  keccak_round_ctrl_if #(.RND_W(5), .CNT_W(16)) b0 ();
  keccak_round_ctrl_if #(.RND_W(5), .CNT_W(2))  b1 ();

  keccak_round_ctrl #(.NUM_ROUNDS(NR), .RND_W(5), .CNT_W(16)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0)
  );

  keccak_round_ctrl #(.NUM_ROUNDS(1), .RND_W(5), .CNT_W(2)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic pop_chk(ev_kind_t k, int v, output int ev);
    ev_t e;
    ev = -1;
    checks++;
    if (exq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind %0d val %0d at cycle %0d, expected none",
               k, v, cyc);
    end else begin
      e  = exq.pop_front();
      ev = e.val;
      if (e.kind != k || e.cyc != cyc || e.val != v) begin
        errors++;
        $display("FAIL event: got kind %0d cyc %0d val %0d expected kind %0d cyc %0d val %0d",
                 k, cyc, v, e.kind, e.cyc, e.val);
      end
    end
  endtask

  always @(negedge clk) begin
    int ev;
    if (mon_en) begin
      if (b0.load_state)
        pop_chk(EV_LOAD, 0, ev);
      if (b0.round_en) begin
        pop_chk(EV_ROUND, int'(b0.round_number), ev);
        chk("last_round", int'(b0.last_round), int'(ev == NR - 1));
      end else begin
        chk("round_number_idle", int'(b0.round_number), 0);
      end
      if (b0.done && !done_q)
        pop_chk(EV_DONE, int'(b0.perm_count), ev);
      done_q = b0.done;
      if (b1.round_en)
        chk("nr1_last_round", int'(b1.last_round), 1);
      if (b1.done && !done1_q) begin
        checks++;
        if (q1.size() == 0) begin
          errors++;
          $display("FAIL nr1_unexpected_done: perm_count %0d, expected none",
                   b1.perm_count);
        end else begin
          ev = q1.pop_front();
          if (int'(b1.perm_count) != ev) begin
            errors++;
            $display("FAIL nr1_perm_count: got %0d expected %0d",
                     b1.perm_count, ev);
          end
        end
      end
      done1_q = b1.done;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_ev(ev_kind_t k, int c, int v);
    ev_t e;
    e.kind = k;
    e.cyc  = c;
    e.val  = v;
    exq.push_back(e);
  endtask

  // issue start now; expects load at T+1, rounds T+2.., done T+2+NR
  task automatic issue(int nrounds, int pc, bit full);
    int t = cyc;
    push_ev(EV_LOAD, t + 1, 0);
    for (int k = 0; k < nrounds; k++)
      push_ev(EV_ROUND, t + 2 + k, k);
    if (full)
      push_ev(EV_DONE, t + 2 + NR, pc);
    b0.start = 1'b1;
    tick();
    b0.start = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (b0.done) seen = 1'b1;
      else tick();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL done_timeout: done %0d expected 1", b0.done);
    end
  endtask

  task automatic ack();
    b0.result_ack = 1'b1;
    tick();
    b0.result_ack = 1'b0;
    chk("ready_after_ack", int'(b0.ready), 1);
    chk("done_after_ack", int'(b0.done), 0);
  endtask

  initial begin
    int t;
    b0.start = 0; b0.abort = 0; b0.result_ack = 0;
    b1.start = 0; b1.abort = 0; b1.result_ack = 0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("rst_ready", int'(b0.ready), 1);
    chk("rst_load", int'(b0.load_state), 0);
    chk("rst_round_en", int'(b0.round_en), 0);
    chk("rst_last", int'(b0.last_round), 0);
    chk("rst_done", int'(b0.done), 0);
    chk("rst_rn", int'(b0.round_number), 0);
    chk("rst_pc", int'(b0.perm_count), 0);
    mon_en = 1'b1;
    tick();

    // full run, then done held for 10 cycles without ack
    issue(NR, 1, 1'b1);
    wait_done();
    for (int i = 0; i < 10; i++) begin
      chk("hold_done", int'(b0.done), 1);
      chk("hold_ready", int'(b0.ready), 0);
      tick();
    end
    ack();

    // ack in IDLE ignored; abort wins over start in IDLE
    b0.result_ack = 1'b1;
    tick();
    b0.result_ack = 1'b0;
    chk("idle_ack_ready", int'(b0.ready), 1);
    b0.abort = 1'b1;
    b0.start = 1'b1;
    tick();
    b0.abort = 1'b0;
    b0.start = 1'b0;
    chk("abort_start_ready", int'(b0.ready), 1);
    chk("abort_start_load", int'(b0.load_state), 0);

    // abort while round 12 is presented
    t = cyc;
    issue(13, 0, 1'b0);
    while (cyc < t + 14) tick();
    b0.abort = 1'b1;
    tick();
    b0.abort = 1'b0;
    chk("abort_ready", int'(b0.ready), 1);
    chk("abort_rn", int'(b0.round_number), 0);
    chk("abort_pc", int'(b0.perm_count), 1);
    repeat (3) tick();
    chk("abort_no_done", int'(b0.done), 0);

    // stray starts in ROUND, DONE and with ack
    issue(NR, 2, 1'b1);
    repeat (5) tick();
    b0.start = 1'b1;
    tick();
    b0.start = 1'b0;
    wait_done();
    b0.start = 1'b1;
    tick();
    chk("done_start_ready", int'(b0.ready), 0);
    b0.result_ack = 1'b1;
    tick();
    b0.start = 1'b0;
    b0.result_ack = 1'b0;
    chk("start_ack_ready", int'(b0.ready), 1);
    tick();
    chk("start_ack_noload", int'(b0.load_state), 0);
    chk("start_ack_pc", int'(b0.perm_count), 2);

    // reset while round 5 is presented
    t = cyc;
    issue(6, 0, 1'b0);
    while (cyc < t + 7) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_ready", int'(b0.ready), 1);
    chk("mid_rst_round_en", int'(b0.round_en), 0);
    chk("mid_rst_rn", int'(b0.round_number), 0);
    chk("mid_rst_done", int'(b0.done), 0);
    chk("mid_rst_pc", int'(b0.perm_count), 0);
    tick();
    issue(NR, 1, 1'b1);
    wait_done();
    ack();

    // single-round build, counter wrap over back-to-back runs
    q1 = '{1, 2, 3, 0, 1};
    b1.start = 1'b1;
    b1.result_ack = 1'b1;
    for (int i = 0; i < 60 && q1.size() != 0; i++) tick();
    b1.start = 1'b0;
    tick();
    b1.result_ack = 1'b0;
    repeat (4) tick();
    chk("nr1_queue_empty", q1.size(), 0);
    chk("nr1_final_pc", int'(b1.perm_count), 1);
    chk("sb_queue_empty", exq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
